// File: rtl/rv_boot_pkg.sv
// Shared constants for the RV32I boot sequencer: FSM state codes and load/timeout values.
package rv_boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_RELEASE = 3'd2;
  localparam state_t ST_RUN     = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam int          INSTR_BYTES    = 4;
  localparam logic [31:0] TIMEOUT_RESULT = 32'hDEAD_DEAD;

endpackage

// File: rtl/rv_boot_wdog.sv
// RUN-state watchdog: counts enabled cycles after a clear and flags the CYC-th one.
// Instantiated by rv_boot_sequencer only when RV_BOOT_WDOG_EN is defined.
module rv_boot_wdog #(
  parameter int CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expired is high during the CYC-th enabled cycle, so the owner can act on that edge
  assign expired = en && (cnt_q == CW'(CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv_boot_sequencer.sv
// Boot/run controller: streams a program into IM with the core held in reset, releases it,
// then latches the result on done_flag. Optional RUN watchdog under RV_BOOT_WDOG_EN.
module rv_boot_sequencer
  import rv_boot_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 100,
  parameter int WDOG_CYC  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  input  logic              done_flag,
  input  logic [31:0]       result_in,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] word_count,
  output logic              timeout,
  output logic [2:0]        dbg_state
);

  // Handshake: a word transfers in any cycle where load_valid && load_ready are both high.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic [31:0]       result_q, result_d;
  logic              timeout_q, timeout_d;
  logic              hs, wdog_expired;

  assign load_ready = (state_q == ST_LOAD);
  assign hs         = load_valid && load_ready;
  assign imem_we    = hs && (load_data != 32'h0);
  assign imem_addr  = {wc_q[ADDR_W-3:0], 2'b00};
  assign imem_wdata = load_data;
  assign core_rst   = (state_q == ST_RUN);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RELEASE) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign result     = result_q;
  assign word_count = wc_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

`ifdef RV_BOOT_WDOG_EN
  rv_boot_wdog #(.CYC(WDOG_CYC)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_RELEASE),
    .en      (state_q == ST_RUN),
    .expired (wdog_expired)
  );
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYC == 0);
  assign wdog_expired    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          wc_d      = '0;
          result_d  = '0;
          timeout_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          if (load_data == 32'h0) begin
            // an empty program never releases the core
            state_d = (wc_q != '0) ? ST_RELEASE : ST_DONE;
          end else begin
            wc_d = wc_q + 1'b1;
            if (wc_q == ADDR_W'(MAX_WORDS - 1)) state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN: begin
        if (done_flag) begin
          result_d = result_in;
          state_d  = ST_DONE;
        end else if (wdog_expired) begin
          result_d  = TIMEOUT_RESULT;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wc_q      <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rv_boot_sequencer.sv
// Directed-random bench for rv_boot_sequencer; watchdog scenarios run when RV_BOOT_WDOG_EN is set.
module tb_rv_boot_sequencer;
  import rv_boot_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 100;
  localparam int WDOG_CYC  = 16;

  logic              clk, rst, start, load_valid, load_ready, imem_we, core_rst;
  logic              done_flag, busy, done, timeout;
  logic [31:0]       load_data, imem_wdata, result_in, result;
  logic [ADDR_W-1:0] imem_addr, word_count;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_count;
  logic [ADDR_W+31:0] exp_q[$];

  rv_boot_sequencer #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .WDOG_CYC(WDOG_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done_flag(done_flag), .result_in(result_in), .busy(busy),
    .done(done), .result(result), .word_count(word_count), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every IM write must match the next expected {addr, data}
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [ADDR_W+31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL imem_write: observed=%0h expected=none", {imem_addr, imem_wdata});
      end else begin
        e = exp_q.pop_front();
        assert ({imem_addr, imem_wdata} === e) else begin
          errors++;
          $error("FAIL imem_write: observed=%0h expected=%0h", {imem_addr, imem_wdata}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_count = 0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_result", result, 0);
    chk("start_wc", word_count, 0);
    chk("start_timeout", timeout, 0);
  endtask

  task automatic load_words(input int n, input bit term);
    logic [31:0] w;
    int total;
    total = n + (term ? 1 : 0);
    for (int i = 0; i < total; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        load_valid = 1'b0;
        load_data  = $urandom;
        #1;
        chk("stall_ready", load_ready, 1);
        tick();
      end
      if (i < n) begin
        w = $urandom;
        if (w == 32'h0) w = 32'h1;
        exp_q.push_back({ADDR_W'((exp_count * INSTR_BYTES) % (1 << ADDR_W)), w});
        exp_count++;
      end else begin
        w = 32'h0;
      end
      load_valid = 1'b1;
      load_data  = w;
      #1;
      chk("load_ready", load_ready, 1);
      chk("core_rst_load", core_rst, 0);
      tick();
    end
    load_valid = 1'b0;
    load_data  = 32'h0;
  endtask

  // entered one cycle into RELEASE; leaves the DUT in RUN
  task automatic release_step(input int n);
    chk("rel_core_rst", core_rst, 0);
    chk("rel_busy", busy, 1);
    chk("rel_ready", load_ready, 0);
    chk("rel_wc", word_count, n);
    tick();
  endtask

  task automatic finish_run(input int cycles, input logic [31:0] res);
    for (int c = 0; c < cycles; c++) begin
      done_flag = 1'b0;
      result_in = $urandom;
      #1;
      chk("run_core_rst", core_rst, 1);
      tick();
    end
    done_flag = 1'b1;
    result_in = res;
    #1;
    chk("run_core_rst", core_rst, 1);
    tick();
    done_flag = 1'b0;
    result_in = $urandom;
    chk("fin_done", done, 1);
    chk("fin_result", result, res);
    chk("fin_core_rst", core_rst, 0);
    chk("fin_busy", busy, 0);
    chk("fin_timeout", timeout, 0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0;
    done_flag = 1'b0; result_in = '0;
    tick();
    tick();
    chk("rst_core_rst", core_rst, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_result", result, 0);
    chk("rst_wc", word_count, 0);
    rst = 1'b1;
    tick();
    chk("idle_core_rst", core_rst, 0);

    // 1: five words plus terminator
    start_load();
    load_words(5, 1'b1);
    release_step(5);
    finish_run($urandom_range(0, 10), 32'd42);
    chk("t1_wc", word_count, 5);

    // 2: empty program
    start_load();
    load_words(0, 1'b1);
    chk("t2_done", done, 1);
    chk("t2_result", result, 0);
    chk("t2_wc", word_count, 0);
    chk("t2_core_rst", core_rst, 0);
    tick();
    chk("t2_core_rst_hold", core_rst, 0);

    // 3: full-length program, no terminator needed
    start_load();
    load_words(MAX_WORDS, 1'b0);
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    #1;
    chk("t3_ready", load_ready, 0);
    chk("t3_wc", word_count, MAX_WORDS);
    chk("t3_core_rst", core_rst, 0);
    tick();
    load_valid = 1'b0;
    chk("t3_run", core_rst, 1);
    r = $urandom;
    finish_run($urandom_range(0, 5), r);

    // 4: reset in the middle of LOAD
    start_load();
    load_words(3, 1'b0);
    chk("t4_wc_pre", word_count, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_core_rst", core_rst, 0);
    chk("t4_ready", load_ready, 0);
    chk("t4_wc", word_count, 0);
    chk("t4_result", result, 0);
    tick();
    chk("t4_idle_ready", load_ready, 0);
    start_load();
    load_words(2, 1'b1);
    release_step(2);
    r = $urandom;
    finish_run($urandom_range(0, 10), r);

    // 5: stray starts ignored; start in DONE reloads
    start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_load_ready", load_ready, 1);
    chk("t5_load_busy", busy, 1);
    load_words(4, 1'b1);
    release_step(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_run_core_rst", core_rst, 1);
    chk("t5_run_done", done, 0);
    r = 32'hCAFE_0001;
    finish_run($urandom_range(0, 5), r);
    start_load();
    load_words(3, 1'b1);
    release_step(3);
    r = 32'h0BAD_F00D;
    finish_run($urandom_range(0, 10), r);

`ifdef RV_BOOT_WDOG_EN
    // 6a: watchdog expiry
    start_load();
    load_words(1, 1'b1);
    release_step(1);
    for (int k = 1; k < WDOG_CYC; k++) begin
      chk("t6_wait_busy", busy, 1);
      tick();
    end
    chk("t6_last_busy", busy, 1);
    tick();
    chk("t6_done", done, 1);
    chk("t6_timeout", timeout, 1);
    chk("t6_result", result, 32'hDEAD_DEAD);
    chk("t6_core_rst", core_rst, 0);
    // 6b: done_flag on the expiry cycle wins
    start_load();
    load_words(1, 1'b1);
    release_step(1);
    for (int k = 1; k < WDOG_CYC; k++) tick();
    r = 32'h0000_0077;
    finish_run(0, r);
`else
    // RUN waits indefinitely without the watchdog
    start_load();
    load_words(1, 1'b1);
    release_step(1);
    r = $urandom;
    finish_run(200, r);
`endif

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
